// File: rtl/dram_res_assembler_pkg.sv
// Shared widths and types for the DRAM response assembler and scratchpad write path.
package dram_res_assembler_pkg;

    localparam int unsigned DRAM_BEAT_W    = 64;
    localparam int unsigned SCPAD_ROW_W    = 512;
    localparam int unsigned DRAM_MAX_BEATS = SCPAD_ROW_W / DRAM_BEAT_W;
    localparam int unsigned DRAM_ID_W      = 8;
    localparam int unsigned DRAM_XBAR_W    = 32;
    localparam int unsigned DRAM_CNT_W     = $clog2(DRAM_MAX_BEATS);

    typedef logic [7:0]  slot_mask_t;
    typedef logic [7:0]  shift_mask_t;
    typedef logic [15:0] mask_t;

    typedef struct packed {
        slot_mask_t  slot;
        shift_mask_t shift;
        mask_t       mask;
    } dram_xbar_desc_t;

    typedef logic [SCPAD_ROW_W-1:0] scpad_data_t;

    typedef struct packed {
        logic            valid;
        scpad_data_t     wdata;
        dram_xbar_desc_t xbar;
    } sram_write_req_t;

    typedef logic [DRAM_CNT_W-1:0] beat_cnt_t;

    typedef enum logic {
        CTX_FREE,
        CTX_FILL
    } ctx_state_e;

endpackage

// File: rtl/dram_res_assembler_if.sv
// DRAM response beat bus plus scratchpad SRAM write request bus.
interface dram_res_assembler_if;
    import dram_res_assembler_pkg::*;

    logic                   dram_res_valid;
    logic                   dram_res_ready;
    logic [DRAM_ID_W-1:0]   dram_id;
    logic [DRAM_BEAT_W-1:0] dram_rddata;
    beat_cnt_t              num_request;
    logic [DRAM_XBAR_W-1:0] xbar;
    logic                   be_stall;
    logic                   sram_wr_valid;
    scpad_data_t            sram_wr_data;
    logic [DRAM_XBAR_W-1:0] sram_wr_xbar;
    logic                   sram_write_req_latched;

    modport slave (
        input  dram_res_valid, dram_id, dram_rddata, num_request, xbar, be_stall,
        output dram_res_ready, sram_wr_valid, sram_wr_data, sram_wr_xbar, sram_write_req_latched
    );

    modport master (
        output dram_res_valid, dram_id, dram_rddata, num_request, xbar, be_stall,
        input  dram_res_ready, sram_wr_valid, sram_wr_data, sram_wr_xbar, sram_write_req_latched
    );

endinterface

// File: rtl/dram_res_assembler_out_fifo.sv
// Synchronous FIFO holding completed rows; head is exposed combinationally (zero when empty).
module dram_res_out_fifo #(
    parameter  int unsigned WIDTH = 544,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty after wrap-around.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dram_res_assembler.sv
// Assembles interleaved DRAM read beats into scratchpad rows across NUM_CTX contexts.
// Optional DRAM_RES_PERF_CNT_EN adds saturating stall_cycles / rows_done counters.
module dram_res_assembler
    import dram_res_assembler_pkg::*;
#(
    parameter  int unsigned BEAT_W    = DRAM_BEAT_W,
    parameter  int unsigned ROW_W     = SCPAD_ROW_W,
    parameter  int unsigned ID_W      = DRAM_ID_W,
    parameter  int unsigned NUM_CTX   = 4,
    parameter  int unsigned XBAR_W    = DRAM_XBAR_W,
    parameter  int unsigned OUT_DEPTH = 4,
    localparam int unsigned MAX_BEATS = ROW_W / BEAT_W,
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS),
    localparam int unsigned CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    dram_res_assembler_if.slave  bus,
    output logic [NUM_CTX-1:0]   ctx_busy
`ifdef DRAM_RES_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          rows_done
`endif
);

    ctx_state_e         ctx_state     [NUM_CTX];
    ctx_state_e         ctx_state_nxt [NUM_CTX];
    logic [ID_W-1:0]    ctx_id        [NUM_CTX];
    logic [CNT_W-1:0]   ctx_cnt       [NUM_CTX];
    logic [CNT_W-1:0]   ctx_last      [NUM_CTX];
    logic [XBAR_W-1:0]  ctx_xbar      [NUM_CTX];
    logic [ROW_W-1:0]   ctx_data      [NUM_CTX];

    logic               hit, any_free, ready, accept, row_done;
    logic [CTX_W-1:0]   hit_idx, free_idx, sel;
    logic [CNT_W-1:0]   cur_cnt, cur_last;
    logic [XBAR_W-1:0]  cur_xbar;
    logic [ROW_W-1:0]   base_data, merged;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(OUT_DEPTH):0] fifo_count;
    logic [ROW_W+XBAR_W-1:0]    fifo_head;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NUM_CTX; i++) begin
            if (ctx_state[i] == CTX_FILL && ctx_id[i] == bus.dram_id) begin
                hit     = 1'b1;
                hit_idx = CTX_W'(i);
            end
            if (ctx_state[i] == CTX_FREE && !any_free) begin
                any_free = 1'b1;
                free_idx = CTX_W'(i);
            end
        end
    end

    assign ready    = !fifo_full && (hit || any_free);
    assign accept   = bus.dram_res_valid && ready;
    assign sel      = hit ? hit_idx : free_idx;
    assign cur_cnt  = hit ? ctx_cnt[sel]  : '0;
    assign cur_last = hit ? ctx_last[sel] : bus.num_request;
    assign cur_xbar = hit ? ctx_xbar[sel] : bus.xbar;
    // A fresh allocation starts from an all-zero buffer so unused beats stay zero.
    assign base_data = hit ? ctx_data[sel] : '0;
    assign row_done  = accept && (cur_cnt == cur_last);

    always_comb begin
        merged = base_data;
        for (int unsigned k = 0; k < MAX_BEATS; k++) begin
            if (CNT_W'(k) == cur_cnt) merged[k*BEAT_W +: BEAT_W] = bus.dram_rddata;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CTX; i++) begin
            ctx_state_nxt[i] = ctx_state[i];
            if (accept && sel == CTX_W'(i)) ctx_state_nxt[i] = row_done ? CTX_FREE : CTX_FILL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_CTX; i++) ctx_state[i] <= CTX_FREE;
        end else begin
            for (int unsigned i = 0; i < NUM_CTX; i++) ctx_state[i] <= ctx_state_nxt[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_CTX; i++) begin
                ctx_id[i]   <= '0;
                ctx_cnt[i]  <= '0;
                ctx_last[i] <= '0;
                ctx_xbar[i] <= '0;
                ctx_data[i] <= '0;
            end
        end else if (accept && !row_done) begin
            ctx_id[sel]   <= bus.dram_id;
            ctx_cnt[sel]  <= cur_cnt + 1'b1;
            ctx_last[sel] <= cur_last;
            ctx_xbar[sel] <= cur_xbar;
            ctx_data[sel] <= merged;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CTX; i++) ctx_busy[i] = (ctx_state[i] == CTX_FILL);
    end

    assign fifo_pop = !fifo_empty && !bus.be_stall;

    dram_res_out_fifo #(
        .WIDTH (ROW_W + XBAR_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (row_done),
        .wr_data ({merged, cur_xbar}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assert property (@(posedge CLK) disable iff (RST) fifo_empty == (fifo_count == '0));

    assign bus.dram_res_ready         = ready;
    assign bus.sram_wr_valid          = !fifo_empty;
    assign bus.sram_wr_data           = fifo_head[ROW_W+XBAR_W-1:XBAR_W];
    assign bus.sram_wr_xbar           = fifo_head[XBAR_W-1:0];
    assign bus.sram_write_req_latched = fifo_pop;

`ifdef DRAM_RES_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
            rows_done    <= '0;
        end else begin
            if (!fifo_empty && bus.be_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (row_done && rows_done != '1) rows_done <= rows_done + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_res_assembler.sv
// Scoreboard bench for dram_res_assembler: directed rows, interleave, exhaustion, backpressure, reset.
module tb_dram_res_assembler;
    import dram_res_assembler_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dram_res_assembler_if bus();
    logic [3:0] ctx_busy;
`ifdef DRAM_RES_PERF_CNT_EN
    logic [31:0] stall_cycles, rows_done;
`endif

    dram_res_assembler #(
        .BEAT_W    (64),
        .ROW_W     (512),
        .ID_W      (8),
        .NUM_CTX   (4),
        .XBAR_W    (32),
        .OUT_DEPTH (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus),
        .ctx_busy     (ctx_busy)
`ifdef DRAM_RES_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .rows_done    (rows_done)
`endif
    );

    typedef struct {
        logic [511:0] data;
        logic [31:0]  xbar;
        int unsigned  cyc;
        bit           lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned n_latched = 0;
    int unsigned n_pushed = 0;

    always @(posedge CLK) cyc++;

    function automatic logic [63:0] beat_val(input logic [7:0] tag, input int unsigned k);
        return {tag, 48'h0, 8'(k)};
    endfunction

    function automatic logic [511:0] mk_row(input logic [7:0] tag, input int unsigned nreq);
        logic [511:0] r = '0;
        for (int unsigned k = 0; k <= nreq; k++) r[k*64 +: 64] = beat_val(tag, k);
        return r;
    endfunction

    function automatic logic [31:0] xb_of(input logic [7:0] id);
        return {id, 8'h5A, ~id, 8'hC3};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Non-first beats carry junk num_request/xbar to prove they are only sampled on beat 0.
    task automatic send_beat(input logic [7:0] id, input logic [7:0] tag, input int unsigned k,
                             input int unsigned nreq, input logic [31:0] xb, input bit lat);
        bit ok = 1'b0;
        bus.dram_res_valid = 1'b1;
        bus.dram_id        = id;
        bus.dram_rddata    = beat_val(tag, k);
        bus.num_request    = (k == 0) ? 3'(nreq) : 3'(~nreq);
        bus.xbar           = (k == 0) ? xb : ~xb;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge CLK);
            if (bus.dram_res_ready) ok = 1'b1;
            @(posedge CLK);
            #1;
        end
        bus.dram_res_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout id=%h beat=%0d actual=not_ready required=accepted", id, k);
        end else if (k == nreq) begin
            sb.push_back('{mk_row(tag, nreq), xb, cyc, lat});
            n_pushed++;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || bus.sram_wr_valid) && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        n_cmp++;
        if (t >= 100) begin
            n_err++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
        end
    endtask

    always @(negedge CLK) begin
        if (bus.sram_write_req_latched) n_latched++;
        if (!RST && bus.sram_wr_valid && !bus.be_stall) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write actual=%h required=none", bus.sram_wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_data", bus.sram_wr_data, e.data);
                chk("wr_xbar", bus.sram_wr_xbar, e.xbar);
                chk("latched_on_pop", bus.sram_write_req_latched, 1);
                if (e.lat) chk("latency", cyc, e.cyc);
            end
        end else if (bus.sram_write_req_latched) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_latched actual=1 required=0");
        end
    end

    initial begin
        int unsigned l0;
        bus.dram_res_valid = 1'b0;
        bus.dram_id        = '0;
        bus.dram_rddata    = '0;
        bus.num_request    = '0;
        bus.xbar           = '0;
        bus.be_stall       = 1'b0;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_ctx_busy", ctx_busy, 0);
        chk("rst_wr_valid", bus.sram_wr_valid, 0);
        chk("rst_wr_data", bus.sram_wr_data, 0);
        chk("rst_wr_xbar", bus.sram_wr_xbar, 0);
        chk("rst_latched", bus.sram_write_req_latched, 0);
        chk("rst_ready", bus.dram_res_ready, 1);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Single row held under stall, then released
        bus.be_stall = 1'b1;
        for (int unsigned k = 0; k < 8; k++) send_beat(8'h11, 8'h00, k, 7, 32'hA5C3_0F1E, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            chk("single_hold_valid", bus.sram_wr_valid, 1);
            chk("single_beat7", bus.sram_wr_data[511:448], 64'h7);
            chk("single_beat3", bus.sram_wr_data[255:192], 64'h3);
            chk("single_xbar", bus.sram_wr_xbar, 32'hA5C3_0F1E);
        end
        @(posedge CLK);
        #1;
        l0 = n_latched;
        bus.be_stall = 1'b0;
        @(posedge CLK);
        #1;
        chk("single_latched_cnt", n_latched - l0, 1);
        chk("single_empty_after", bus.sram_wr_valid, 0);

        // Interleaved ids 0xA / 0xB
        for (int unsigned k = 0; k < 4; k++) begin
            send_beat(8'h0A, 8'h0A, k, 3, xb_of(8'h0A), 1'b0);
            send_beat(8'h0B, 8'h0B, k, 3, xb_of(8'h0B), 1'b0);
        end
        wait_drain();

        // Context exhaustion
        for (int unsigned id = 1; id <= 4; id++) send_beat(8'(id), 8'(id), 0, 3, xb_of(8'(id)), 1'b0);
        bus.dram_id = 8'h05;
        @(negedge CLK);
        chk("exh_ctx_busy", ctx_busy, 4'hF);
        chk("exh_miss_ready", bus.dram_res_ready, 0);
        bus.dram_id = 8'h02;
        @(negedge CLK);
        chk("exh_hit_ready", bus.dram_res_ready, 1);
        @(posedge CLK);
        #1;
        send_beat(8'h02, 8'h02, 1, 3, xb_of(8'h02), 1'b0);
        bus.dram_id = 8'h05;
        @(negedge CLK);
        chk("exh_miss_ready2", bus.dram_res_ready, 0);
        @(posedge CLK);
        #1;
        for (int unsigned k = 1; k < 4; k++) send_beat(8'h01, 8'h01, k, 3, xb_of(8'h01), 1'b0);
        for (int unsigned k = 0; k < 4; k++) send_beat(8'h05, 8'h05, k, 3, xb_of(8'h05), 1'b0);
        for (int unsigned k = 2; k < 4; k++) send_beat(8'h02, 8'h02, k, 3, xb_of(8'h02), 1'b0);
        for (int unsigned k = 1; k < 4; k++) send_beat(8'h03, 8'h03, k, 3, xb_of(8'h03), 1'b0);
        for (int unsigned k = 1; k < 4; k++) send_beat(8'h04, 8'h04, k, 3, xb_of(8'h04), 1'b0);
        wait_drain();

        // Backpressure: fill the output FIFO
        bus.be_stall = 1'b1;
        for (int unsigned id = 8'h21; id <= 8'h24; id++) begin
            send_beat(8'(id), 8'(id), 0, 1, xb_of(8'(id)), 1'b0);
            send_beat(8'(id), 8'(id), 1, 1, xb_of(8'(id)), 1'b0);
        end
        bus.dram_id = 8'h30;
        repeat (10) begin
            @(negedge CLK);
            chk("bp_ready", bus.dram_res_ready, 0);
            chk("bp_hold_data", bus.sram_wr_data, mk_row(8'h21, 1));
        end
        chk("bp_hold_xbar", bus.sram_wr_xbar, xb_of(8'h21));
        @(posedge CLK);
        #1;
        l0 = n_latched;
        bus.be_stall = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("bp_consecutive_latched", bus.sram_write_req_latched, 1);
        end
        @(negedge CLK);
        chk("bp_after_latched", bus.sram_write_req_latched, 0);
        @(posedge CLK);
        #1;
        chk("bp_latched_cnt", n_latched - l0, 4);
        wait_drain();

        // One-beat rows back to back
        for (int unsigned id = 0; id < 6; id++) send_beat(8'(id), 8'(8'h40 + id), 0, 0, xb_of(8'(id)), 1'b1);
        wait_drain();

        // Reset mid-row
        for (int unsigned k = 0; k < 3; k++) send_beat(8'h77, 8'h66, k, 7, xb_of(8'h66), 1'b0);
        @(negedge CLK);
        chk("mid_ctx_busy", ctx_busy, 4'b0001);
        @(posedge CLK);
        #1 RST = 1'b1;
        n_pushed = 0;
        @(negedge CLK);
        chk("mrst_ctx_busy", ctx_busy, 0);
        chk("mrst_wr_valid", bus.sram_wr_valid, 0);
        chk("mrst_wr_data", bus.sram_wr_data, 0);
        chk("mrst_wr_xbar", bus.sram_wr_xbar, 0);
        chk("mrst_ready", bus.dram_res_ready, 1);
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int unsigned k = 0; k < 8; k++) send_beat(8'h77, 8'h77, k, 7, xb_of(8'h77), 1'b1);
        wait_drain();
        chk("final_queue_empty", sb.size(), 0);
`ifdef DRAM_RES_PERF_CNT_EN
        chk("perf_rows_done", rows_done, n_pushed);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
